// File: rtl/seq_addsub_pkg.sv
// Shared types and sizing helpers for the sequential adder/subtractor.
// Default geometry is a 32-bit datapath processed in 8-bit slices.
package seq_addsub_pkg;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_SLICE = 8;
   localparam int unsigned NSLICE    = DEF_WIDTH / DEF_SLICE;

   // Slice index needs at least one bit even when the whole word is a single slice.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned IDX_W = idx_width(NSLICE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_addsub_if.sv
// Start/done handshake and result bus of the sequential adder/subtractor.
// The requester uses the master view, the arithmetic unit the slave view.
interface seq_addsub_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic             sub_mode;
   logic [WIDTH-1:0] input_a;
   logic [WIDTH-1:0] input_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             overflow;

   modport master (
      output start, sub_mode, input_a, input_b,
      input  busy, done, sum, carry, overflow
   );

   modport slave (
      input  start, sub_mode, input_a, input_b,
      output busy, done, sum, carry, overflow
   );
endinterface

// File: rtl/seq_addsub_slice.sv
// One SLICE-bit ripple step: unsigned a + b + cin, widened by one bit for the carry.
module addsub_slice #(
   parameter int unsigned SLICE = 8
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] s,
   output logic             cout
);

   logic [SLICE:0] total;

   always_comb begin
      total = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
      s     = total[SLICE-1:0];
      cout  = total[SLICE];
   end

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: one SLICE-bit group per clock with a registered
// ripple carry, producing unsigned carry and signed overflow flags on completion.
module seq_addsub
   import seq_addsub_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned SLICE = DEF_SLICE
) (
   input logic        clk,
   input logic        rst_n,
   seq_addsub_if.slave bus
);

   localparam int unsigned    NSL      = WIDTH / SLICE;
   localparam int unsigned    IW       = idx_width(NSL);
   localparam logic [IW-1:0]  LAST_IDX = IW'(NSL - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic             cry_q;
   logic             carry_q;
   logic             ovf_q;
   logic [IW-1:0]    idx_q;

   logic [SLICE-1:0] a_sl;
   logic [SLICE-1:0] b_sl;
   logic [SLICE-1:0] s_sl;
   logic             cout;
   logic             accept;
   logic             last;

   // Single shared slice adder; operand groups are selected by the slice index.
   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int unsigned i = 0; i < NSL; i++) begin
         if (idx_q == IW'(i)) begin
            a_sl = a_q[i*SLICE +: SLICE];
            b_sl = b_q[i*SLICE +: SLICE];
         end
      end
   end

   addsub_slice #(
      .SLICE (SLICE)
   ) u_slice (
      .a    (a_sl),
      .b    (b_sl),
      .cin  (cry_q),
      .s    (s_sl),
      .cout (cout)
   );

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last      = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         RUN: begin
            if (idx_q == LAST_IDX) begin
               last      = 1'b1;
               state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cry_q   <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         idx_q   <= '0;
      end else if (accept) begin
         // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
         a_q   <= bus.input_a;
         b_q   <= bus.sub_mode ? ~bus.input_b : bus.input_b;
         cry_q <= bus.sub_mode;
         idx_q <= '0;
      end else if (state == RUN) begin
         for (int unsigned i = 0; i < NSL; i++) begin
            if (idx_q == IW'(i)) begin
               sum_q[i*SLICE +: SLICE] <= s_sl;
            end
         end
         cry_q <= cout;
         idx_q <= idx_q + IW'(1);
         if (last) begin
            carry_q <= cout;
            ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_sl[SLICE-1] != a_q[WIDTH-1]);
         end
      end
   end

   assign bus.busy     = (state == RUN);
   assign bus.done     = (state == DONE);
   assign bus.sum      = sum_q;
   assign bus.carry    = carry_q;
   assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Scoreboard bench for seq_addsub: directed corner cases plus random operations,
// expected results from plain 64-bit arithmetic, checked by an independent monitor.
module tb_seq_addsub;
   import seq_addsub_pkg::*;

   localparam int unsigned W = 32;

   typedef struct {
      logic [W-1:0] sum;
      logic         carry;
      logic         ovf;
      int unsigned  cyc;
      string        name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [W-1:0] last_sum = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_addsub_if #(.WIDTH(W)) bus ();

   seq_addsub #(
      .WIDTH (W),
      .SLICE (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
   endtask

   function automatic exp_t model(input bit sub, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t        e;
      longint unsigned ua, ub, ur;
      longint      sa, sb, sr;
      ua = a;
      ub = b;
      sa = $signed(a);
      sb = $signed(b);
      if (sub) begin
         ur      = ua - ub;
         sr      = sa - sb;
         e.carry = (ua >= ub);
      end else begin
         ur      = ua + ub;
         sr      = sa + sb;
         e.carry = (ur > 64'hFFFF_FFFF);
      end
      e.sum  = ur[W-1:0];
      e.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      e.cyc  = 0;
      e.name = "";
      return e;
   endfunction

   // Presents one request for a single edge; call at posedge+1 with the DUT able to accept.
   task automatic issue(input string nm, input bit sub, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e = model(sub, a, b);
      e.name = nm;
      bus.start    = 1'b1;
      bus.sub_mode = sub;
      bus.input_a  = a;
      bus.input_b  = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      e.cyc = cyc + NSLICE;
      exp_q.push_back(e);
      last_sum = e.sum;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((bus.busy || bus.done) && n < 30) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 30) begin
         n_checks++;
         $display("FAIL idle_timeout: busy=%0b done=%0b still set after %0d cycles", bus.busy, bus.done, n);
      end else begin
         chk("hold_sum", bus.sum, last_sum);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_done: done=1 with no outstanding request, sum=0x%0h (t=%0t)", bus.sum, $time);
         end else begin
            mon_e = exp_q.pop_front();
            chk({mon_e.name, "_sum"}, bus.sum, mon_e.sum);
            chk({mon_e.name, "_carry"}, bus.carry, mon_e.carry);
            chk({mon_e.name, "_ovf"}, bus.overflow, mon_e.ovf);
            chk({mon_e.name, "_latency"}, cyc, mon_e.cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start    = 1'b0;
      bus.sub_mode = 1'b0;
      bus.input_a  = '0;
      bus.input_b  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_sum", bus.sum, 0);
      chk("rst_carry", bus.carry, 0);
      chk("rst_ovf", bus.overflow, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      issue("add_small", 1'b0, 32'h0000_0000, 32'h0000_4000);  wait_idle();
      issue("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);   wait_idle();
      issue("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001);    wait_idle();
      issue("sub_borrow", 1'b1, 32'h0000_0000, 32'h0000_4000); wait_idle();
      issue("sub_noborrow", 1'b1, 32'hFFFF_FFFF, 32'h0000_0001); wait_idle();
      issue("sub_ovf", 1'b1, 32'h8000_0000, 32'h0000_0001);    wait_idle();
      issue("sub_equal", 1'b1, 32'h1234_5678, 32'h1234_5678);  wait_idle();

      // Requests during RUN must be ignored; a request in the DONE cycle is taken.
      issue("busy_orig", 1'b0, 32'h1234_5678, 32'h1111_1111);
      bus.start    = 1'b1;
      bus.sub_mode = 1'b1;
      bus.input_a  = 32'hDEAD_BEEF;
      bus.input_b  = 32'hCAFE_F00D;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("done_cycle_state", bus.done, 1);
      issue("b2b_second", 1'b1, 32'h0000_0010, 32'h0000_0020);
      wait_idle();

      // Asynchronous abort in the middle of an operation.
      issue("rst_abort", 1'b0, 32'hAAAA_0000, 32'h5555_FFFF);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_sum", bus.sum, 0);
      chk("abort_carry", bus.carry, 0);
      chk("abort_ovf", bus.overflow, 0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      issue("add_3_4", 1'b0, 32'd3, 32'd4);
      wait_idle();

      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra, rb;
         bit           rs;
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 4) == 0) ra = {1'b1, {(W-1){1'b0}}} ^ W'($urandom_range(0, 1));
         if ($urandom_range(0, 4) == 0) rb = '1;
         issue($sformatf("rnd%0d", i), rs, ra, rb);
         if ($urandom_range(0, 2) == 0) begin
            repeat (NSLICE) begin
               @(posedge clk);
               #1;
            end
         end else begin
            wait_idle();
         end
      end
      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
- Multi-cycle adder/subtractor for the RV32 datapath, complementing the combinational `subtractor`.
- Adds or subtracts two WIDTH-bit operands SLICE bits per clock, ripple carry held in a register.
- Start/done handshake.
- Trades latency for area; produces carry and signed-overflow flags for branch/compare logic.

Parameters:
- WIDTH, 32: operand and result width.
- SLICE, 8: bits processed per cycle. Must divide WIDTH; with the defaults NSLICE = WIDTH/SLICE = 4.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when busy=0.
- sub_mode  in  1  0 = input_a + input_b, 1 = input_a - input_b. Sampled with start.
- input_a  in  WIDTH  operand A, sampled with start.
- input_b  in  WIDTH  operand B, sampled with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: result valid.
- sum  out  WIDTH  result.
- carry  out  1  carry out of the MSB. In subtract mode, 1 = no borrow (input_a >= input_b unsigned).
- overflow  out  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n low, async): state=IDLE; busy, done, carry, overflow = 0; sum = 0; internal operand, carry and slice-index registers = 0.
- States are IDLE, RUN, DONE.
- IDLE or DONE, start=1 at edge k:
  - Latch A; latch B' = sub_mode ? ~input_b : input_b.
  - Carry register <= sub_mode; slice index <= 0; state <= RUN.
  - busy=1 from edge k.
- RUN, each edge:
  - Slice i result = A[i] + B'[i] + carry register, where [i] is the i-th SLICE-bit group (bits i*SLICE .. i*SLICE+SLICE-1).
  - Write slice i result into sum; update carry register; increment index.
  - At the edge that completes slice NSLICE-1:
    - carry <= final carry.
    - overflow <= (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]).
    - done <= 1, busy <= 0, state <= DONE.
- Latency: done is high in the cycle after edge k+NSLICE (4 cycles with defaults).
- DONE lasts exactly one cycle, then goes to IDLE; done returns to 0.
- start high in DONE is accepted like IDLE (back-to-back ops, no bubble). done still clears.
- start while busy=1 is ignored. Operands and mode are not re-sampled; the in-flight op completes unchanged.
- sum, carry and overflow hold their last result until the next accepted start.
- sum is undefined during RUN; it is written slice by slice. Consumers use it only when done=1 or in IDLE.
- Wrap-around: arithmetic is modulo 2^WIDTH; the final carry appears only on the carry port.
- Reset asserted mid-RUN aborts immediately to the reset state; no done pulse is produced.
- Arithmetic is unsigned slice addition of width SLICE+1; no signed types internally.

Decomposition:
- Package seq_addsub_pkg:
  - State enum (IDLE, RUN, DONE).
  - Localparam NSLICE = WIDTH/SLICE.
  - Index width = clog2(NSLICE), minimum 1.
- Sub-module addsub_slice, combinational: SLICE-bit a, b, cin -> SLICE-bit s, cout.
- The top instantiates one addsub_slice, muxed by slice index.

Test Plan:
- add 0x00000000 + 0x00004000 -> done exactly 4 cycles after start; sum=0x00004000, carry=0, overflow=0.
- add 0xFFFFFFFF + 0x00000001 -> sum=0x00000000, carry=1, overflow=0.
- add 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, carry=0, overflow=1.
- sub 0x00000000 - 0x00004000 -> sum=0xFFFFC000, carry=0 (borrow). Then sub 0xFFFFFFFF - 0x00000001 -> sum=0xFFFFFFFE, carry=1. Covers sub 0x80000000 - 0x00000001 -> sum=0x7FFFFFFF, overflow=1.
- start pulsed again at cycles 1 and 2 of a busy op with different operands:
  - Ignored; the original result is returned, with a single done pulse.
  - start held during the DONE cycle -> second op accepted; its done follows 4 cycles later.
- rst_n dropped at cycle 2 of RUN -> busy, done, sum, carry and overflow go to 0 asynchronously; no done pulse. After release, a new add 3+4 -> 0x00000007.
